// File: rtl/seq_booth_mul_if.sv
// Operand/result bundle between the control unit (master) and the sequential multiplier (slave).
interface seq_booth_mul_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  signed_mode;
  logic [DATA_WIDTH-1:0] Q;
  logic [DATA_WIDTH-1:0] M;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] HI;
  logic [DATA_WIDTH-1:0] LO;

  modport master (output start, signed_mode, Q, M, input busy, done, HI, LO);
  modport slave  (input start, signed_mode, Q, M, output busy, done, HI, LO);
endinterface

// File: rtl/seq_booth_mul.sv
// Radix-4 Booth multiplier retiring one digit per clock; signed/unsigned per operation,
// 2*DATA_WIDTH product published on HI/LO only when the operation completes.
module seq_booth_mul #(
  parameter int DATA_WIDTH = 32
) (
  input  logic            clk,
  input  logic            clr_n,
  seq_booth_mul_if.slave  bus
);
  localparam int W    = DATA_WIDTH;
  localparam int ITER = W/2 + 1;
  localparam int AW   = 2*W + 2;
  localparam int CW   = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [AW-1:0] acc, acc_nxt, mcand, pp;
  logic [W+2:0]  mplr;
  logic [W-1:0]  hi_q, lo_q;
  logic          last;

  assign last = (cnt == CW'(ITER-1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // mcand is pre-shifted by 2i and mplr[2:0] holds bits [2i+1:2i-1], so no barrel shifter is needed
  always_comb begin
    pp = '0;
    case (mplr[2:0])
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand << 1;
      3'b100:         pp = -(mcand << 1);
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
    acc_nxt = acc + pp;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.start) begin
          mcand <= {{(W+2){bus.signed_mode & bus.Q[W-1]}}, bus.Q};
          mplr  <= {{2{bus.signed_mode & bus.M[W-1]}}, bus.M, 1'b0};
          acc   <= '0;
          cnt   <= '0;
        end
        RUN: begin
          acc   <= acc_nxt;
          mcand <= mcand << 2;
          mplr  <= mplr >> 2;
          cnt   <= cnt + 1'b1;
          if (last) {hi_q, lo_q} <= acc_nxt[2*W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
endmodule

// File: tb/tb_seq_booth_mul.sv
// Bench for seq_booth_mul: cycle-level product model checked every cycle, plus directed
// literal expectations for latency, extremes, reset and ignored starts.
module tb_seq_booth_mul;
  localparam int DW   = 32;
  localparam int ITER = DW/2 + 1;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  seq_booth_mul_if #(.DATA_WIDTH(DW)) bus();

  seq_booth_mul #(.DATA_WIDTH(DW)) dut (.clk(clk), .clr_n(clr_n), .bus(bus));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint pa, pb;
    if (s) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'({32'b0, a});
      pb = longint'({32'b0, b});
    end
    return 64'(pa * pb);
  endfunction

  // Model: phase 0 = idle, 1..ITER = digit cycles, ITER+1 = result cycle
  int          m_ph = 0;
  logic [63:0] m_pend = '0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_busy, m_done;
  assign m_busy = (m_ph != 0);
  assign m_done = (m_ph == ITER+1);

  always @(posedge clk) begin
    if (!clr_n) begin
      m_ph <= 0; m_hi <= '0; m_lo <= '0;
    end else if (m_ph == 0) begin
      if (bus.start) begin
        m_ph   <= 1;
        m_pend <= ref_prod(bus.signed_mode, bus.Q, bus.M);
      end
    end else if (m_ph == ITER) begin
      m_ph <= ITER+1;
      {m_hi, m_lo} <= m_pend;
    end else if (m_ph == ITER+1) begin
      m_ph <= 0;
    end else begin
      m_ph <= m_ph + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if (bus.busy !== m_busy || bus.done !== m_done || bus.HI !== m_hi || bus.LO !== m_lo) begin
        n_err++;
        $display("FAIL cycle_model t=%0t: busy/done/HI/LO got %b/%b/%h/%h want %b/%b/%h/%h",
                 $time, bus.busy, bus.done, bus.HI, bus.LO, m_busy, m_done, m_hi, m_lo);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // One operation from IDLE; done must appear in the cycle after the ITER-th edge following acceptance
  task automatic run_op(input string name, input logic s, input logic [31:0] q, input logic [31:0] m,
                        input logic [31:0] eh, input logic [31:0] el);
    int n;
    bit seen;
    check({name, "_model"}, ref_prod(s, q, m), {eh, el});
    @(posedge clk); #1;
    bus.start = 1'b1; bus.signed_mode = s; bus.Q = q; bus.M = m;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.signed_mode = ~s; bus.Q = ~q; bus.M = ~m;
    n = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check({name, "_latency"}, 64'(seen ? n : -1), 64'(ITER));
    check({name, "_result"}, {bus.HI, bus.LO}, {eh, el});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dones;
    bus.start = 1'b0; bus.signed_mode = 1'b0; bus.Q = '0; bus.M = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {bus.HI, bus.LO}, 64'h0);
    check("reset_flags", {62'h0, bus.busy, bus.done}, 64'h0);
    chk_en = 1'b1;
    @(posedge clk); #1 clr_n = 1'b1;

    run_op("signed_neg3x7",   1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("unsigned_max",    1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("signed_max",      1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    run_op("signed_minxmin",  1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("signed_maxxmin",  1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000);
    run_op("unsigned_minxmin",1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("unsigned_2p16sq", 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);

    // Second start three cycles into RUN must be dropped
    @(posedge clk); #1;
    bus.start = 1'b1; bus.signed_mode = 1'b1; bus.Q = 32'd5; bus.M = 32'hFFFF_FFFA;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.start = 1'b1; bus.signed_mode = 1'b0; bus.Q = 32'h0001_0000; bus.M = 32'h0001_0000;
    @(posedge clk); #1 bus.start = 1'b0;
    dones = 0;
    repeat (ITER + 6) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    check("ignored_start_pulses", 64'(dones), 64'd1);
    check("ignored_start_held", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFE2);

    // Reset mid-RUN abandons the operation
    @(posedge clk); #1;
    bus.start = 1'b1; bus.signed_mode = 1'b0; bus.Q = 32'd9; bus.M = 32'd9;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 clr_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrun_reset_hilo", {bus.HI, bus.LO}, 64'h0);
    check("midrun_reset_flags", {62'h0, bus.busy, bus.done}, 64'h0);
    #1 clr_n = 1'b1;
    dones = 0;
    repeat (ITER + 5) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    check("midrun_reset_no_done", 64'(dones), 64'd0);

    // Back-to-back with start held; operands churn every cycle, model captures on acceptance
    @(posedge clk); #1 bus.start = 1'b1;
    repeat (200 * (ITER + 2)) begin
      @(posedge clk); #1;
      bus.signed_mode = 1'($urandom_range(0, 1));
      bus.Q = pick();
      bus.M = pick();
    end
    bus.start = 1'b0;
    repeat (ITER + 4) @(posedge clk);
    @(negedge clk);
    check("drain_idle", {63'h0, bus.busy}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
